dmem_dump_uart: RTL

//  Downstream readback stage for the 256x8 data RAM. On completion of a program run
//  (control unit's done), scans the RAM from address 0 through NUM_WORDS-1 over the
//  RAM's read port and streams each byte out as 8N1 UART, so results are checked off-chip.

---
 rtl/dmem_dump_uart_if.sv | 12 +
 rtl/dmem_dump_uart.sv | 91 +++++++++
 2 files changed

// File: rtl/dmem_dump_uart_if.sv
// dmem_dump_uart_if: trigger, RAM read port and UART/status signals of the RAM dump stage.
interface dmem_dump_uart_if;
   logic       start;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata;
   logic       tx;
   logic       busy;
   logic       finished;
   logic [8:0] byte_cnt;
   modport master (input start, mem_rdata, output mem_addr, tx, busy, finished, byte_cnt);
   modport slave (output start, mem_rdata, input mem_addr, tx, busy, finished, byte_cnt);
endinterface

// File: rtl/dmem_dump_uart.sv
// dmem_dump_uart: on a rising start, reads the data RAM from address 0 upward
// and sends each byte as an 8N1 UART frame.
module dmem_dump_uart #(
   parameter int CLKS_PER_BIT = 868,
   parameter int NUM_WORDS = 256,
   parameter int RD_LAT = 1
) (
   input logic clk,
   input logic rst,
   dmem_dump_uart_if.master bus
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   typedef enum logic [2:0] {IDLE, RD, WAIT, START, DATA, STOP} state_t;
   state_t state;
   logic start_q;
   logic [BW-1:0] baud;
   logic [2:0] bit_idx;
   logic [1:0] wcnt;
   logic [7:0] shift;
   logic trigger, last_tick, timed;
   assign trigger = bus.start & ~start_q;
   assign last_tick = baud == BW'(CLKS_PER_BIT - 1);
   assign timed = state inside {START, DATA, STOP};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         start_q <= 1'b0;
         baud <= '0;
         bit_idx <= '0;
         wcnt <= '0;
         shift <= '0;
         bus.mem_addr <= '0;
         bus.tx <= 1'b1;
         bus.busy <= 1'b0;
         bus.finished <= 1'b0;
         bus.byte_cnt <= '0;
      end else begin
         start_q <= bus.start;
         // baud restarts on each bit boundary and stays at zero outside the timed states
         baud <= (timed && !last_tick) ? baud + BW'(1) : '0;
         case (state)
            IDLE: if (trigger) begin
               bus.mem_addr <= '0;
               bus.byte_cnt <= '0;
               bus.finished <= 1'b0;
               bus.busy <= 1'b1;
               state <= RD;
            end
            RD: begin
               wcnt <= 2'(RD_LAT);
               state <= WAIT;
            end
            WAIT: begin
               wcnt <= wcnt - 2'd1;
               if (wcnt == 2'd1) begin
                  shift <= bus.mem_rdata;
                  bus.tx <= 1'b0;
                  state <= START;
               end
            end
            START: if (last_tick) begin
               bus.tx <= shift[0];
               bit_idx <= '0;
               state <= DATA;
            end
            DATA: if (last_tick) begin
               if (bit_idx == 3'd7) begin
                  bus.tx <= 1'b1;
                  state <= STOP;
               end else begin
                  bus.tx <= shift[1];
                  shift <= shift >> 1;
                  bit_idx <= bit_idx + 3'd1;
               end
            end
            STOP: if (last_tick) begin
               bus.byte_cnt <= bus.byte_cnt + 9'd1;
               if (bus.byte_cnt == 9'(NUM_WORDS - 1)) begin
                  bus.busy <= 1'b0;
                  bus.finished <= 1'b1;
                  state <= IDLE;
               end else begin
                  bus.mem_addr <= bus.mem_addr + 8'd1;
                  state <= RD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
